// File: rtl/codec_cfg_seq_pkg.sv
// codec_cfg_seq_pkg: state encoding, table size and counter widths shared by the
// WM8731 configuration sequencer.
package codec_cfg_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_LOW,
        S_FAIL,
        S_SETTLE,
        S_DONE,
        S_ERROR
    } state_t;
    localparam int NUM_REGS = 11;
    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);
    localparam int TO_W = 21;
    localparam int ST_W = 16;
endpackage

// File: rtl/codec_cfg_seq_sync_rise.sv
// codec_cfg_seq_sync_rise: 2-flop synchroniser with a rising-edge pulse on the
// synchronised level.
module codec_cfg_seq_sync_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise
);
    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
endmodule

// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: walks the WM8731 power-up register table, handing each word to the
// i2c master with GO/END handshake, retries, timeout and post-reset settle delay.
module codec_cfg_seq
    import codec_cfg_seq_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR      = 8'h34,
    parameter int         SETTLE_CYCLES = 50_000,
    parameter int         TIMEOUT       = 2_000_000,
    parameter int         MAX_RETRY     = 3,
    parameter bit         AUTO_START    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        i2c_end,
    input  logic        i2c_ack_ok,
    output logic [23:0] i2c_data,
    output logic        i2c_go,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  reg_index
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [ST_W-1:0]   st_q, st_d;
    logic [23:0]       data_q, data_d;
    logic              again_q, again_d;
    logic              first_q;
    logic              ack_m_q, ack_s_q;
    logic              end_lvl, end_rise;
    logic [15:0]       rom_word;

    codec_cfg_seq_sync_rise u_end_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i2c_end),
        .level (end_lvl),
        .rise  (end_rise)
    );

    always_comb begin
        case (idx_q)
            4'd0:    rom_word = 16'h1E00;
            4'd1:    rom_word = 16'h0017;
            4'd2:    rom_word = 16'h0217;
            4'd3:    rom_word = 16'h0479;
            4'd4:    rom_word = 16'h0679;
            4'd5:    rom_word = 16'h0812;
            4'd6:    rom_word = 16'h0A00;
            4'd7:    rom_word = 16'h0C00;
            4'd8:    rom_word = 16'h0E4A;
            4'd9:    rom_word = 16'h1000;
            4'd10:   rom_word = 16'h1201;
            default: rom_word = 16'h0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        to_d    = to_q;
        st_d    = st_q;
        data_d  = data_q;
        again_d = again_q;
        case (state_q)
            S_IDLE: begin
                if (start || (AUTO_START && first_q)) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            S_LOAD: begin
                data_d  = {DEV_ADDR, rom_word};
                to_d    = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                to_d = (to_q == '1) ? to_q : to_q + 1'b1;
                // end_rise wins over a timeout expiring in the same cycle
                if (end_rise)
                    state_d = ack_s_q ? S_WAIT_LOW : S_FAIL;
                else if (to_q >= TO_W'(TIMEOUT - 1))
                    state_d = S_FAIL;
            end
            S_WAIT_LOW: begin
                if (!end_lvl) begin
                    again_d = 1'b0;
                    if (again_q)
                        state_d = S_LOAD;
                    else if (idx_q == '0) begin
                        state_d = S_SETTLE;
                        st_d    = '0;
                    end else if (idx_q == LAST_IDX)
                        state_d = S_DONE;
                    else begin
                        idx_d   = idx_q + 1'b1;
                        retry_d = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_FAIL: begin
                if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    again_d = 1'b1;
                    state_d = S_WAIT_LOW;
                end else
                    state_d = S_ERROR;
            end
            S_SETTLE: begin
                st_d = (st_q == '1) ? st_q : st_q + 1'b1;
                if (st_q >= ST_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_LOAD;
                    idx_d   = 4'd1;
                    retry_d = '0;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            to_q    <= '0;
            st_q    <= '0;
            data_q  <= '0;
            again_q <= 1'b0;
            first_q <= 1'b1;
            ack_m_q <= 1'b0;
            ack_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            to_q    <= to_d;
            st_q    <= st_d;
            data_q  <= data_d;
            again_q <= again_d;
            first_q <= 1'b0;
            ack_m_q <= i2c_ack_ok;
            ack_s_q <= ack_m_q;
        end
    end

    assign i2c_data  = data_q;
    assign i2c_go    = (state_q == S_SEND);
    assign busy      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign reg_index = idx_q;
endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb_codec_cfg_seq: randomized i2c slave model around codec_cfg_seq, checked against
// an expected word list built from the register table and retry rules.
module tb_codec_cfg_seq;
    localparam int SETTLE = 20;
    localparam int TMO    = 64;
    localparam int MAXR   = 3;

    logic        clk = 1'b0;
    logic        reset, start, i2c_end, i2c_ack_ok;
    logic [23:0] i2c_data;
    logic        i2c_go, busy, done, error;
    logic [3:0]  reg_index;

    logic [15:0] tbl [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                              16'h0A00, 16'h0C00, 16'h0E4A, 16'h1000, 16'h1201};

    int          n_cmp, n_bad, cyc, scen, stab_bad;
    logic [23:0] nack_word, silent_word;
    int          nack_times;
    logic [23:0] log_q [$];
    int          rise_q [$], len_q [$], fall_q [$];
    logic [23:0] exp_q [$];
    int          exp_err, exp_last;

    codec_cfg_seq #(
        .DEV_ADDR      (8'h34),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT       (TMO),
        .MAX_RETRY     (MAXR),
        .AUTO_START    (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .i2c_end    (i2c_end),
        .i2c_ack_ok (i2c_ack_ok),
        .i2c_data   (i2c_data),
        .i2c_go     (i2c_go),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .reg_index  (reg_index)
    );

    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every go pulse: word at rise, rise cycle, high length; word must not move while go is high
    initial begin
        logic        prev;
        logic [23:0] cur;
        int          run;
        prev = 1'b0; cur = '0; run = 0; stab_bad = 0;
        forever begin
            @(negedge clk);
            if (i2c_go && !prev) begin
                cur = i2c_data;
                log_q.push_back(i2c_data);
                rise_q.push_back(cyc);
            end
            if (i2c_go) begin
                run++;
                if (i2c_data !== cur) stab_bad++;
            end else if (prev) begin
                len_q.push_back(run);
                run = 0;
            end
            prev = i2c_go;
        end
    end

    // i2c master model: answers after a random delay, holds END until go drops, then a bit more
    initial begin
        logic [23:0] w, last_w;
        int          tries, last_scen;
        i2c_end = 1'b0; i2c_ack_ok = 1'b0; last_w = '0; tries = 0; last_scen = -1;
        forever begin
            @(negedge clk);
            if (i2c_go) begin
                w = i2c_data;
                tries = (w == last_w && scen == last_scen) ? tries + 1 : 1;
                last_w = w;
                last_scen = scen;
                if (w != silent_word) begin
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    i2c_ack_ok = !(w == nack_word && tries <= nack_times);
                    i2c_end = 1'b1;
                end
                while (i2c_go) @(negedge clk);
                repeat ($urandom_range(0, 4)) @(negedge clk);
                fall_q.push_back(cyc);
                i2c_end = 1'b0;
                i2c_ack_ok = 1'b0;
            end
        end
    end

    // Expected words: each entry once, plus one resend per NACK/timeout, up to MAXR+1 tries
    task automatic build_exp(input int nidx, input int ntimes, input int sidx);
        exp_q.delete();
        exp_err = 0;
        exp_last = 10;
        for (int i = 0; i < 11; i++) begin
            int fails, tries;
            fails = (i == sidx) ? 1000 : (i == nidx) ? ntimes : 0;
            tries = (fails > MAXR) ? MAXR + 1 : fails + 1;
            repeat (tries) exp_q.push_back({8'h34, tbl[i]});
            if (fails > MAXR) begin
                exp_err = 1;
                exp_last = i;
                break;
            end
        end
    endtask

    task automatic set_policy(input int nidx, input int ntimes, input int sidx);
        scen++;
        nack_word   = (nidx >= 0) ? {8'h34, tbl[nidx]} : 24'hFFFFFF;
        nack_times  = ntimes;
        silent_word = (sidx >= 0) ? {8'h34, tbl[sidx]} : 24'hFFFFFF;
        build_exp(nidx, ntimes, sidx);
    endtask

    task automatic pulse_start(output int c);
        @(negedge clk);
        start = 1'b1;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(done || error) && t < 3000);
        check({tag, ":finished"}, 32'(done || error), 32'd1);
        repeat (12) @(negedge clk);
    endtask

    task automatic run_check(input string tag, input int base);
        int n;
        n = log_q.size() - base;
        check({tag, ":count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check($sformatf("%s:w%0d", tag, i), 32'(log_q[base + i]), 32'(exp_q[i]));
        check({tag, ":done"}, 32'(done), 32'(exp_err == 0));
        check({tag, ":error"}, 32'(error), 32'(exp_err));
        check({tag, ":reg_index"}, 32'(reg_index), exp_last);
        check({tag, ":go"}, 32'(i2c_go), 32'd0);
        check({tag, ":busy"}, 32'(busy), 32'd0);
        check({tag, ":stable"}, stab_bad, 32'd0);
    endtask

    initial begin
        int base, c, t;
        n_cmp = 0; n_bad = 0; scen = 0; start = 1'b0; reset = 1'b1;
        nack_word = 24'hFFFFFF; silent_word = 24'hFFFFFF; nack_times = 0;
        repeat (3) @(negedge clk);
        check("rst:data", 32'(i2c_data), 32'd0);
        check("rst:go", 32'(i2c_go), 32'd0);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:error", 32'(error), 32'd0);
        check("rst:reg_index", 32'(reg_index), 32'd0);

        set_policy(-1, 0, -1);
        reset = 1'b0;
        c = cyc;
        wait_end("ack_all");
        run_check("ack_all", 0);
        check("ack_all:last_data", 32'(i2c_data), 32'h341201);
        if (rise_q.size() >= 3) begin
            check("ack_all:latency", rise_q[0] - c, 32'd2);
            check("ack_all:settle_gap", (rise_q[1] - fall_q[0]) - (rise_q[2] - fall_q[1]), SETTLE);
        end

        set_policy(4, 2, -1);
        base = log_q.size();
        pulse_start(c);
        t = 0;
        while (log_q.size() < base + 3 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("nack4x2");
        run_check("nack4x2", base);
        if (rise_q.size() > base) check("nack4x2:latency", rise_q[base] - c, 32'd2);

        set_policy(2, 99, -1);
        base = log_q.size();
        pulse_start(c);
        wait_end("nack2");
        run_check("nack2", base);

        set_policy(-1, 0, 7);
        base = log_q.size();
        pulse_start(c);
        wait_end("silent7");
        run_check("silent7", base);
        for (int k = 0; k < 4; k++)
            if (len_q.size() > base + 7 + k)
                check($sformatf("silent7:go_len%0d", k), len_q[base + 7 + k], TMO);

        set_policy(-1, 0, -1);
        pulse_start(c);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(i2c_go && reg_index == 4'd6) && t < 3000);
        check("rst_mid:reached", 32'(i2c_go), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid:go", 32'(i2c_go), 32'd0);
        check("rst_mid:busy", 32'(busy), 32'd0);
        check("rst_mid:data", 32'(i2c_data), 32'd0);
        check("rst_mid:reg_index", 32'(reg_index), 32'd0);
        repeat (15) @(negedge clk);
        reset = 1'b0;
        c = cyc;
        base = log_q.size();
        wait_end("rst_mid");
        run_check("rst_mid", base);
        if (rise_q.size() > base) check("rst_mid:latency", rise_q[base] - c, 32'd2);

        for (int r = 0; r < 6; r++) begin
            int ni, nt;
            ni = $urandom_range(0, 10);
            nt = $urandom_range(0, 5);
            set_policy(ni, nt, -1);
            base = log_q.size();
            pulse_start(c);
            wait_end($sformatf("rand%0d", r));
            run_check($sformatf("rand%0d_e%0d_n%0d", r, ni, nt), base);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
